dmem_port_arbiter: RTL and testbench

//  Shares one single-port 32x32 data memory between two MEM-stage requesters (pipe 0, pipe 1).

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_rsp_tracker.sv | 48 ++++
 rtl/dmem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dual-pipe data memory port arbiter.
package dmem_pkg;

   localparam int unsigned MEM_IDX_W = 5;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned HALF_W    = 16;

   localparam logic [1:0] BE_HI  = 2'b10;
   localparam logic [1:0] BE_LO  = 2'b01;
   localparam logic [1:0] BE_ALL = 2'b11;

   typedef enum logic {RSP_IDLE, RSP_WAIT} rsp_state_e;

   // Select the halfword owned by a pipe: hi=1 picks [31:16], hi=0 picks [15:0].
   function automatic logic [HALF_W-1:0] pick_half(input logic [WORD_W-1:0] word,
                                                   input logic              hi);
      return hi ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
   endfunction

endpackage

// File: rtl/dmem_rsp_tracker.sv
// Per-pipe read response tracker: flags the cycle after a read grant and holds the
// last returned halfword between responses.
module dmem_rsp_tracker
   import dmem_pkg::*;
#(
   parameter bit HALF = 1'b1  // 1: upper halfword [31:16], 0: lower halfword [15:0]
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              rd_gnt_i,
   input  logic [WORD_W-1:0] mem_rdata_i,
   output logic              rvalid_o,
   output logic [HALF_W-1:0] rdata_o
);

   rsp_state_e        state_q;
   logic [HALF_W-1:0] rdata_q;
   logic [HALF_W-1:0] mem_half;

   assign mem_half = pick_half(mem_rdata_i, HALF);

   // Response FSM: WAIT marks the cycle the memory returns data; latch it for later hold.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= RSP_IDLE;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            RSP_IDLE: state_q <= rd_gnt_i ? RSP_WAIT : RSP_IDLE;
            RSP_WAIT: begin
               rdata_q <= mem_half;
               state_q <= rd_gnt_i ? RSP_WAIT : RSP_IDLE;
            end
         endcase
      end
   end

   // Memory data passes straight through in the WAIT cycle; a reset cycle drops the response.
   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = '0;
      if (!reset_i) begin
         rvalid_o = (state_q == RSP_WAIT);
         rdata_o  = rvalid_o ? mem_half : rdata_q;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-pipe arbiter for a single-port 32x32 data memory. Pipe 0 owns the upper
// halfword, pipe 1 the lower. Compatible requests merge into one access; others
// are served round-robin with a one-cycle worst-case wait.
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned IDX_W  = MEM_IDX_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [HALF_W-1:0] wdata0_i,
   input  logic [HALF_W-1:0] wdata1_i,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              stall0_o,
   output logic              stall1_o,
   output logic              rvalid0_o,
   output logic              rvalid1_o,
   output logic [HALF_W-1:0] rdata0_o,
   output logic [HALF_W-1:0] rdata1_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [1:0]        mem_be_o,
   output logic [IDX_W-1:0]  mem_idx_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   input  logic [WORD_W-1:0] mem_rdata_i,
   output logic [CNT_W-1:0]  conflicts_o
);

   logic [IDX_W-1:0] idx0, idx1;
   logic             both_req, merge, conflict;
   logic             gnt0, gnt1;
   logic             prio_q, prio_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             unused_addr_hi;

   assign idx0 = addr0_i[IDX_W-1:0];
   assign idx1 = addr1_i[IDX_W-1:0];

   // Address bits above the word index are ignored by design.
   assign unused_addr_hi = ^{addr0_i[ADDR_W-1:IDX_W], addr1_i[ADDR_W-1:IDX_W]};

   // Arbitration: merge same-word same-direction pairs, else prio wins; nothing during reset.
   always_comb begin
      both_req = req0_i & req1_i;
      merge    = both_req && (idx0 == idx1) && (we0_i == we1_i);
      conflict = both_req & ~merge & ~reset_i;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (!reset_i) begin
         if (merge) begin
            gnt0 = 1'b1;
            gnt1 = 1'b1;
         end else if (both_req) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = req0_i;
            gnt1 = req1_i;
         end
      end
   end

   // Memory command for the granted access; each pipe's data lands in its own halfword.
   always_comb begin
      mem_be_o = 2'b00;
      if (gnt0 && gnt1) begin
         mem_be_o = BE_ALL;
      end else if (gnt0) begin
         mem_be_o = BE_HI;
      end else if (gnt1) begin
         mem_be_o = BE_LO;
      end
      mem_en_o    = gnt0 | gnt1;
      mem_we_o    = gnt0 ? we0_i : (gnt1 & we1_i);
      mem_idx_o   = gnt0 ? idx0 : (gnt1 ? idx1 : '0);
      mem_wdata_o = {wdata0_i & {HALF_W{gnt0}}, wdata1_i & {HALF_W{gnt1}}};
   end

   assign gnt0_o      = gnt0;
   assign gnt1_o      = gnt1;
   assign stall0_o    = req0_i & ~gnt0 & ~reset_i;
   assign stall1_o    = req1_i & ~gnt1 & ~reset_i;
   assign conflicts_o = reset_i ? '0 : cnt_q;

   // Next-state: loser of a conflict gets priority next; conflict counter saturates.
   always_comb begin
      prio_d = prio_q;
      cnt_d  = cnt_q;
      if (conflict) begin
         prio_d = gnt0;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         prio_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prio_q <= prio_d;
         cnt_q  <= cnt_d;
      end
   end

   dmem_rsp_tracker #(
      .HALF(1'b1)
   ) u_rsp0 (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .rd_gnt_i    (gnt0 & ~we0_i),
      .mem_rdata_i (mem_rdata_i),
      .rvalid_o    (rvalid0_o),
      .rdata_o     (rdata0_o)
   );

   dmem_rsp_tracker #(
      .HALF(1'b0)
   ) u_rsp1 (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .rd_gnt_i    (gnt1 & ~we1_i),
      .mem_rdata_i (mem_rdata_i),
      .rvalid_o    (rvalid1_o),
      .rdata_o     (rdata1_o)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed scenarios plus random traffic,
// with a behavioural memory macro and an independent reference model.
module tb_dmem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, stall0, stall1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic        mem_en, mem_we;
   logic [1:0]  mem_be;
   logic [4:0]  mem_idx;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [15:0] conflicts;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          due;
      logic [15:0] data;
   } rsp_t;

   rsp_t        q0[$];
   rsp_t        q1[$];
   logic [31:0] ref_mem [32];
   bit          m_prio;
   int          m_conf;
   bit          m_g0, m_g1;
   int          run0, run1, max_run;

   // Pending-request state for held-until-granted traffic.
   bit          p0, p1, pw0, pw1;
   logic [31:0] pa0, pa1;
   logic [15:0] pd0, pd1;

   dmem_port_arbiter dut (
      .clock_i     (clock),
      .reset_i     (reset),
      .req0_i      (req0),
      .req1_i      (req1),
      .we0_i       (we0),
      .we1_i       (we1),
      .addr0_i     (addr0),
      .addr1_i     (addr1),
      .wdata0_i    (wdata0),
      .wdata1_i    (wdata1),
      .gnt0_o      (gnt0),
      .gnt1_o      (gnt1),
      .stall0_o    (stall0),
      .stall1_o    (stall1),
      .rvalid0_o   (rvalid0),
      .rvalid1_o   (rvalid1),
      .rdata0_o    (rdata0),
      .rdata1_o    (rdata1),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_be_o    (mem_be),
      .mem_idx_o   (mem_idx),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .conflicts_o (conflicts)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] seed_word(input int i);
      if (i == 3) return 32'hAAAA_5555;
      return 32'h9E37_79B9 * 32'(i + 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: actual=%0h required=no response (cycle %0d)", name, act, cyc);
   endtask

   // Behavioural single-port memory: command sampled before the edge, applied at it.
   initial begin : mem_model
      logic [31:0] marr [32];
      logic        s_en, s_we;
      logic [1:0]  s_be;
      logic [4:0]  s_idx;
      logic [31:0] s_wd;
      for (int i = 0; i < 32; i++) marr[i] = seed_word(i);
      forever begin
         @(negedge clock);
         s_en = mem_en; s_we = mem_we; s_be = mem_be; s_idx = mem_idx; s_wd = mem_wdata;
         @(posedge clock);
         if (s_en) begin
            if (s_we) begin
               if (s_be[1]) marr[s_idx][31:16] = s_wd[31:16];
               if (s_be[0]) marr[s_idx][15:0] = s_wd[15:0];
            end else begin
               mem_rdata <= marr[s_idx];
            end
         end
      end
   end

   // Reference model: who is served this cycle, what the memory sees, what reads return.
   task automatic model_and_check();
      logic [4:0]  i0, i1;
      bit          clash;
      logic [31:0] ew;
      i0 = addr0[4:0];
      i1 = addr1[4:0];
      clash = 0;
      m_g0 = 0;
      m_g1 = 0;
      if (!reset) begin
         if (req0 && req1 && !(i0 == i1 && we0 == we1)) begin
            clash = 1;
            if (m_prio == 0) m_g0 = 1; else m_g1 = 1;
         end else begin
            m_g0 = req0;
            m_g1 = req1;
         end
      end
      chk("gnt0", gnt0, m_g0);
      chk("gnt1", gnt1, m_g1);
      chk("stall0", stall0, req0 && !reset && !m_g0);
      chk("stall1", stall1, req1 && !reset && !m_g1);
      chk("mem_en", mem_en, m_g0 || m_g1);
      chk("mem_be", mem_be, {m_g0, m_g1});
      chk("conflicts", conflicts, reset ? 0 : m_conf);
      if (reset) begin
         chk("rvalid0_in_reset", rvalid0, 0);
         chk("rvalid1_in_reset", rvalid1, 0);
      end
      if (m_g0 || m_g1) begin
         chk("mem_we", mem_we, m_g0 ? we0 : we1);
         chk("mem_idx", mem_idx, m_g0 ? i0 : i1);
         if (m_g0 ? we0 : we1) begin
            ew = {m_g0 ? wdata0 : 16'h0, m_g1 ? wdata1 : 16'h0};
            chk("mem_wdata", mem_wdata, ew);
         end
      end
      if (m_g0 && !we0) q0.push_back('{due: cyc + 1, data: ref_mem[i0][31:16]});
      if (m_g1 && !we1) q1.push_back('{due: cyc + 1, data: ref_mem[i1][15:0]});
      if (m_g0 && we0) ref_mem[i0][31:16] = wdata0;
      if (m_g1 && we1) ref_mem[i1][15:0] = wdata1;
      if (reset) begin
         m_prio = 0;
         m_conf = 0;
      end else if (clash) begin
         m_prio = ~m_prio;
         if (m_conf < 65535) m_conf++;
      end
      run0 = stall0 ? run0 + 1 : 0;
      run1 = stall1 ? run1 + 1 : 0;
      if (run0 > max_run) max_run = run0;
      if (run1 > max_run) max_run = run1;
   endtask

   task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [15:0] d0,
                        input bit r1, input bit w1, input logic [31:0] a1, input logic [15:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clock);
      model_and_check();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   // Requests are held with stable payload until the model says they were granted.
   task automatic traffic(input int n, input int pct, input bit split);
      for (int k = 0; k < n; k++) begin
         if (!p0 && $urandom_range(99) < pct) begin
            p0 = 1; pw0 = 1'($urandom_range(1)); pd0 = 16'($urandom);
            pa0 = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(3));
            if (split) pa0[0] = 1'b0;
         end
         if (!p1 && $urandom_range(99) < pct) begin
            p1 = 1; pw1 = 1'($urandom_range(1)); pd1 = 16'($urandom);
            pa1 = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(3));
            if (split) pa1[0] = 1'b1;
         end
         drive(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
         if (m_g0) p0 = 0;
         if (m_g1) p1 = 0;
      end
   endtask

   // Monitor: every rvalid must match the oldest outstanding read due this cycle.
   always @(negedge clock) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
         chk("rvalid0", rvalid0, 1);
         chk("rdata0", rdata0, q0[0].data);
         void'(q0.pop_front());
      end else if (rvalid0) begin
         flag("rvalid0_spurious", rdata0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
         chk("rvalid1", rvalid1, 1);
         chk("rdata1", rdata1, q1[0].data);
         void'(q1.pop_front());
      end else if (rvalid1) begin
         flag("rvalid1_spurious", rdata1);
      end
   end

   initial begin : main
      logic [31:0] w4;
      for (int i = 0; i < 32; i++) ref_mem[i] = seed_word(i);
      w4 = seed_word(4);

      // Reset state.
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);
      chk("rdata0_reset", rdata0, 16'h0);
      chk("rdata1_reset", rdata1, 16'h0);

      // Single read on pipe 0; upper address bits must be ignored.
      drive(1, 0, 32'hDEAD_0003, 16'h0, 0, 0, '0, '0);
      idle(2);
      chk("rdata0_hold", rdata0, 16'hAAAA);

      // Merged write of both halves of one word.
      drive(1, 1, 32'h0000_0007, 16'h1234, 1, 1, 32'h0000_0007, 16'h5678);
      idle(1);

      // Sustained conflicts alternate grants.
      traffic(6, 100, 1'b1);
      traffic(3, 0, 1'b0);

      // A single conflict: pipe 0 first, pipe 1 the next cycle.
      drive(1, 0, 32'h1, '0, 1, 0, 32'h2, '0);
      drive(0, 0, '0, '0, 1, 0, 32'h2, '0);
      idle(1);

      // Write then reads of the same word.
      drive(1, 1, 32'h4, 16'hBEEF, 0, 0, '0, '0);
      drive(0, 0, '0, '0, 1, 0, 32'h4, '0);
      drive(1, 0, 32'h4, '0, 0, 0, '0, '0);
      idle(2);
      chk("rdata0_raw", rdata0, 16'hBEEF);
      chk("rdata1_old", rdata1, w4[15:0]);

      // Random traffic with frequent merges and conflicts.
      traffic(400, 60, 1'b0);
      traffic(3, 0, 1'b0);

      // Reset while a read response is in flight.
      drive(1, 0, 32'h9, '0, 0, 0, '0, '0);
      reset = 1'b1;
      q0.delete();
      q1.delete();
      drive(0, 0, '0, '0, 1, 0, 32'h5, '0);
      reset = 1'b0;
      idle(1);
      chk("rdata0_after_reset", rdata0, 16'h0);
      drive(1, 0, 32'h1, '0, 1, 0, 32'h2, '0);
      drive(0, 0, '0, '0, 1, 0, 32'h2, '0);
      idle(3);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("stall_run_le_1", max_run <= 1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
